fifo_wr_arbiter: RTL

//  Round-robin write arbiter sharing one synchronous FIFO (fifo_write/fifo_data_in/fifo_full)

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundles the producer request/data/ack lines with the FIFO write port.
// The arbiter uses the slave side. The master side is the environment,
// which means the producers plus the FIFO full flag.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        gnt;
  logic                    fifo_full;
  logic                    fifo_write;
  logic [DATA_W-1:0]       fifo_data_in;
  logic                    busy;

  modport master (
    output req, wdata, fifo_full,
    input  ack, gnt, fifo_write, fifo_data_in, busy
  );

  modport slave (
    input  req, wdata, fifo_full,
    output ack, gnt, fifo_write, fifo_data_in, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one FIFO write port among N_REQ producers.
// A grant lasts for a burst of up to BURST_MAX beats. Writes stall while the FIFO is full.
// N_REQ and DATA_W must match the parameters of the connected interface instance.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_last, w_last_nxt;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;

  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;
  logic               w_write;
  logic [N_REQ-1:0]   w_ack;
  logic [N_REQ-1:0]   w_gnt;
  logic [DATA_W-1:0]  w_wdata [N_REQ];

  // Split the flat producer data bus into one word per producer.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_wdata[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: scan from last+1 upward, wrapping around. The previous owner is checked last.
  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = IDX_W'((int'(r_last) + k) % N_REQ);
      if (!w_found && bus.req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // State, owner, last-served and beat counter registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= IDX_W'(N_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Next-state logic and write strobe. A req drop takes precedence over fifo_full.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_beat_cnt_nxt = r_beat_cnt;
    w_write        = 1'b0;
    w_ack          = '0;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_owner_nxt    = w_pick;
          w_state_nxt    = BURST;
          w_beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end else if (!bus.fifo_full) begin
          w_write        = 1'b1;
          w_ack[r_owner] = 1'b1;
          if (r_beat_cnt == CNT_W'(BURST_MAX - 1)) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_owner;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The grant vector follows the registered owner. It is cleared in IDLE.
  always_comb begin
    w_gnt          = '0;
    w_gnt[r_owner] = (r_state == BURST);
  end

  assign bus.ack          = w_ack;
  assign bus.gnt          = w_gnt;
  assign bus.fifo_write   = w_write;
  assign bus.fifo_data_in = w_wdata[r_owner];
  assign bus.busy         = (r_state == BURST);

endmodule
